rv32_lsu_handshake: RTL and testbench
=====================================

Name: rv32_lsu_handshake

Overview:
Parametrised load/store unit for the RV32I multi-cycle cores. It accepts one load or store request at a time from the core. It drives a valid/ready memory bus that tolerates variable wait states and produces byte/halfword/word lane steering with sign or zero extension. It adds behaviour the fixed-timing cores lack: a bus timeout, misaligned-access detection and illegal-funct3 detection, each reported as an error code alongside the response.

Parameters:
ADDR_W, 32, byte-address width; o_mem_addr is ADDR_W bits.
MAX_WAIT, 15, cycles without i_mem_ready before timeout; 0 = no timeout.
CNT_W, 8, wait-counter width; MAX_WAIT must be < 2**CNT_W.

Ports:
i_clk  in  1  clock.
i_rst  in  1  synchronous active-high reset.
i_req_valid  in  1  request present.
o_req_ready  out  1  unit can accept a request (IDLE and not in reset).
i_req_store  in  1  1 = store, 0 = load.
i_req_funct3  in  3  RV32I load/store funct3.
i_req_addr  in  ADDR_W  byte address (rs1+imm).
i_req_wdata  in  32  store data (rs2).
o_rsp_valid  out  1  one-cycle response pulse.
o_rsp_rdata  out  32  extended load data; 0 for stores and errors.
o_rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
o_mem_valid  out  1  bus request.
i_mem_ready  in  1  bus accepts (store) / returns data (load) this cycle.
o_mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
o_mem_rEN  out  1  read access; equals o_mem_valid & ~store.
o_mem_wMASK  out  4  byte write mask; 0 unless o_mem_valid & store.
o_mem_wdata  out  32  lane-replicated store data.
i_mem_rdata  in  32  read word, valid when o_mem_valid & i_mem_ready & load.

Behaviour:
- States: IDLE, BUS, RESP. Reset (i_rst high at a clock edge) sets IDLE, counter 0, and all registered outputs 0. o_req_ready is 0 while i_rst is high.
- Acceptance: i_req_valid & o_req_ready at an edge. All request fields are registered then, and later input changes are ignored.
- Decode at acceptance, checked in this priority:
  - illegal funct3 (load: 011/110/111; store: anything but 000/001/010) -> RESP, err 11;
  - misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> RESP, err 01;
  - otherwise -> BUS.
- Error paths: no bus activity occurs; o_mem_valid never rises.
- BUS:
  - o_mem_valid=1 and all bus outputs are stable from registered fields.
  - Counter cleared on entry.
  - Each cycle with i_mem_ready=1: capture rdata (load), go to RESP with err 00.
  - Each cycle with i_mem_ready=0: if MAX_WAIT!=0 and cnt==MAX_WAIT, go to RESP with err 10; else cnt++.
  - o_mem_valid is therefore high for at most MAX_WAIT+1 cycles.
- RESP: o_rsp_valid=1 for exactly one cycle, then IDLE. o_rsp_valid is 0 in all other states.
- Latency:
  - Accept at edge N; o_mem_valid high during cycle N+1.
  - Ready in cycle N+k gives o_rsp_valid in cycle N+k+1. Minimum is 2 cycles accept-to-response.
  - Error paths: o_rsp_valid in cycle N+1.
- Throughput: o_req_ready is high again in the cycle after RESP. Back-to-back issue is 3 cycles/request minimum.
- Load extraction uses a=addr[1:0]:
  - h = a[1] ? rdata[31:16] : rdata[15:0];
  - b = a[0] ? h[15:8] : h[7:0];
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- Store masks:
  - SB: 0001<<a.
  - SH: a[1] ? 1100 : 0011.
  - SW: 1111.
- Store wdata:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Store response: rdata=0, err=00 on ready.
- Reset mid-operation: takes effect at that edge. o_mem_valid is 0 the next cycle, and no response is produced for the aborted request.
- i_mem_ready outside BUS is ignored.

Test Plan:
- LW addr 0x100, ready on first BUS cycle, rdata 0xDEADBEEF -> o_mem_addr 0x100, rEN 1, rsp 2 cycles after accept, rdata 0xDEADBEEF, err 00.
- LB addr 0x103, rdata 0x80FF_0000 -> rdata 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x205, wdata 0x1234_56AB -> addr 0x204, wMASK 0010, wdata 0xABABABAB; SH addr 0x206 -> wMASK 1100, wdata 0x56AB56AB.
- LW addr 0x101 -> rsp next cycle, err 01, o_mem_valid never high; store funct3 011 -> err 11.
- MAX_WAIT=3, i_mem_ready held 0 -> o_mem_valid high exactly 4 cycles, then rsp err 10, rdata 0; ready asserted on 3rd wait cycle -> err 00.
- i_rst asserted during 2nd BUS cycle -> o_mem_valid 0 next cycle, no o_rsp_valid, o_req_ready 1 after reset released.

Source files
------------

// File: rtl/rv32_lsu_handshake.sv
// rtl/rv32_lsu_handshake.sv - RV32I load/store unit on a valid/ready memory bus
// Decodes one request at a time; reports misaligned, illegal-funct3 and bus-timeout errors.
module rv32_lsu_handshake #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_store,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic [1:0]        o_rsp_err,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rEN,
  output logic [3:0]        o_mem_wMASK,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  state_t            r_state, w_next;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [1:0]        r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept, w_illegal, w_misal, w_timeout;
  logic [15:0]       w_half;
  logic [7:0]        w_byte;
  logic [31:0]       w_load;
  logic [3:0]        w_mask;
  logic [31:0]       w_wdata;

  assign o_req_ready = (r_state == S_IDLE) && !i_rst;
  assign w_accept    = i_req_valid && o_req_ready;

  assign w_illegal = i_req_store ? (i_req_funct3 > 3'd2)
                                 : (i_req_funct3 == 3'b011 || i_req_funct3[2:1] == 2'b11);
  assign w_misal   = (i_req_funct3[1:0] == 2'b01 && i_req_addr[0]) ||
                     (i_req_funct3[1:0] == 2'b10 && i_req_addr[1:0] != 2'b00);
  assign w_timeout = (MAX_WAIT != 0) && (r_cnt == MAX_CNT);

  // Lane steering works from the registered address so bus outputs stay stable across waits
  assign w_half = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
  assign w_byte = r_addr[0] ? w_half[15:8] : w_half[7:0];

  always_comb begin
    w_load = i_mem_rdata;
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'b0, w_byte};
      3'b101:  w_load = {16'b0, w_half};
      default: w_load = i_mem_rdata;
    endcase
  end

  always_comb begin
    w_mask  = 4'b1111;
    w_wdata = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_mask  = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_mask  = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_mask  = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  assign o_mem_valid = (r_state == S_BUS);
  assign o_mem_rEN   = o_mem_valid && !r_store;
  assign o_mem_wMASK = (o_mem_valid && r_store) ? w_mask : 4'b0000;
  assign o_mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_mem_wdata = w_wdata;
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (w_illegal || w_misal) ? S_RESP : S_BUS;
      S_BUS:   if (i_mem_ready || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_store  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'b0;
      r_rdata  <= 32'b0;
      r_err    <= 2'b00;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_store  <= i_req_store;
      r_funct3 <= i_req_funct3;
      r_addr   <= i_req_addr;
      r_wdata  <= i_req_wdata;
      r_rdata  <= 32'b0;
      r_cnt    <= '0;
      r_err    <= w_illegal ? 2'b11 : (w_misal ? 2'b01 : 2'b00);
    end else if (r_state == S_BUS) begin
      if (i_mem_ready) begin
        if (!r_store) r_rdata <= w_load;
        r_err <= 2'b00;
      end else if (w_timeout) begin
        r_err <= 2'b10;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv32_lsu_handshake.sv
// tb/tb_rv32_lsu_handshake.sv - self-checking bench for rv32_lsu_handshake
// Directed and random transactions checked against a behavioural model of the unit.
module tb_rv32_lsu_handshake;

  localparam int ADDR_W   = 32;
  localparam int MAX_WAIT = 3;

  logic              i_clk;
  logic              i_rst;
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_store;
  logic [2:0]        i_req_funct3;
  logic [ADDR_W-1:0] i_req_addr;
  logic [31:0]       i_req_wdata;
  logic              o_rsp_valid;
  logic [31:0]       o_rsp_rdata;
  logic [1:0]        o_rsp_err;
  logic              o_mem_valid;
  logic              i_mem_ready;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_rEN;
  logic [3:0]        o_mem_wMASK;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  rv32_lsu_handshake #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_store(i_req_store), .i_req_funct3(i_req_funct3),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
    .o_mem_addr(o_mem_addr), .o_mem_rEN(o_mem_rEN),
    .o_mem_wMASK(o_mem_wMASK), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [1:0] model_err(input bit st, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    size = 1 << f3[1:0];
    if (st && f3 > 3'd2) return 2'b11;
    if (!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'b11;
    if ((addr % size) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> (8 * a);
    case (f3)
      3'd0:    return 32'($signed(sh[7:0]));
      3'd1:    return 32'($signed(sh[15:0]));
      3'd4:    return sh & 32'h0000_00FF;
      3'd5:    return sh & 32'h0000_FFFF;
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [1:0] a);
    int nbytes;
    nbytes = 1 << f3[1:0];
    return 4'(((1 << nbytes) - 1) << a);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int nbytes;
    nbytes = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes) +: 8];
    return r;
  endfunction

  // rdy_at: index of the BUS cycle in which i_mem_ready is raised (large = never)
  task automatic run_txn(input string name, input bit st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int rdy_at, input logic [31:0] word);
    logic [1:0]  e_err;
    logic [31:0] e_rdata;
    logic [70:0] e_bus, a_bus;
    int e_lat, e_vcnt, vcnt, bus_idx, got_cyc;
    bit got;
    e_err = model_err(st, f3, addr);
    e_bus = {addr & 32'hFFFF_FFFC, !st, st ? model_mask(f3, addr[1:0]) : 4'b0000, model_wdata(f3, wd)};
    if (e_err != 2'b00) begin
      e_lat = 1; e_vcnt = 0; e_rdata = 32'h0;
    end else if (MAX_WAIT != 0 && rdy_at > MAX_WAIT) begin
      e_lat = MAX_WAIT + 2; e_vcnt = MAX_WAIT + 1; e_rdata = 32'h0; e_err = 2'b10;
    end else begin
      e_lat = rdy_at + 2; e_vcnt = rdy_at + 1; e_rdata = st ? 32'h0 : model_load(f3, addr[1:0], word);
    end

    @(negedge i_clk);
    n_cmp++;
    if (o_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s req_ready: got %b need 1", name, o_req_ready);
    end
    i_req_valid = 1'b1; i_req_store = st; i_req_funct3 = f3; i_req_addr = addr; i_req_wdata = wd;
    i_mem_ready = 1'($urandom); i_mem_rdata = $urandom;
    @(negedge i_clk);
    i_req_valid = 1'b0; i_req_store = 1'($urandom); i_req_funct3 = 3'($urandom);
    i_req_addr = $urandom; i_req_wdata = $urandom;

    vcnt = 0; bus_idx = 0; got = 0; got_cyc = 0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      if (cyc > 1) @(negedge i_clk);
      if (o_rsp_valid === 1'b1) begin
        got = 1; got_cyc = cyc;
      end
      if (o_mem_valid === 1'b1) begin
        vcnt++;
        a_bus = {o_mem_addr, o_mem_rEN, o_mem_wMASK, o_mem_wdata};
        n_cmp++;
        if (a_bus !== e_bus) begin
          n_bad++; $display("FAIL %s bus outputs: got %h need %h", name, a_bus, e_bus);
        end
        i_mem_ready = (bus_idx == rdy_at);
        i_mem_rdata = i_mem_ready ? word : $urandom;
        bus_idx++;
      end else begin
        n_cmp++;
        if ({o_mem_rEN, o_mem_wMASK} !== 5'b0) begin
          n_bad++; $display("FAIL %s idle bus: got rEN/mask %b need 0", name, {o_mem_rEN, o_mem_wMASK});
        end
        i_mem_ready = 1'($urandom); i_mem_rdata = $urandom;
      end
    end

    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL %s no response within 40 cycles", name);
    end else begin
      if (got_cyc != e_lat) begin
        n_bad++; $display("FAIL %s latency: got %0d need %0d", name, got_cyc, e_lat);
      end
      n_cmp++;
      if (o_rsp_rdata !== e_rdata || o_rsp_err !== e_err) begin
        n_bad++; $display("FAIL %s response: got %h/%b need %h/%b", name, o_rsp_rdata, o_rsp_err, e_rdata, e_err);
      end
    end
    n_cmp++;
    if (vcnt != e_vcnt) begin
      n_bad++; $display("FAIL %s mem_valid cycles: got %0d need %0d", name, vcnt, e_vcnt);
    end
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    n_cmp++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s after rsp: got rsp/ready %b%b need 01", name, o_rsp_valid, o_req_ready);
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_req_valid = 1'b1; i_req_store = 1'b0; i_req_funct3 = 3'd2;
    i_req_addr = 32'h100; i_req_wdata = 32'h0; i_mem_ready = 1'b0; i_mem_rdata = 32'h0;
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if ({o_req_ready, o_rsp_valid, o_mem_valid, o_mem_rEN, o_mem_wMASK} !== 8'b0) begin
      n_bad++; $display("FAIL reset controls: got %b need 0", {o_req_ready, o_rsp_valid, o_mem_valid, o_mem_rEN, o_mem_wMASK});
    end
    n_cmp++;
    if ({o_rsp_rdata, o_rsp_err, o_mem_addr, o_mem_wdata} !== 98'b0) begin
      n_bad++; $display("FAIL reset data: got %h need 0", {o_rsp_rdata, o_rsp_err, o_mem_addr, o_mem_wdata});
    end
    i_req_valid = 1'b0;
    i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_req_ready !== 1'b1 || o_mem_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset release: got ready/valid %b%b need 10", o_req_ready, o_mem_valid);
    end
  endtask

  task automatic test_loads;
    run_txn("lw_0x100", 0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    run_txn("lb_0x103", 0, 3'd0, 32'h103, 32'h0, 0, 32'h80FF_0000);
    run_txn("lbu_0x103", 0, 3'd4, 32'h103, 32'h0, 1, 32'h80FF_0000);
    run_txn("lh_0x102", 0, 3'd1, 32'h102, 32'h0, 2, 32'h80FF_0000);
    run_txn("lhu_0x102", 0, 3'd5, 32'h102, 32'h0, 0, 32'h80FF_0000);
  endtask

  task automatic test_stores;
    run_txn("sb_0x205", 1, 3'd0, 32'h205, 32'h1234_56AB, 0, 32'h0);
    run_txn("sh_0x206", 1, 3'd1, 32'h206, 32'h1234_56AB, 1, 32'h0);
    run_txn("sw_0x208", 1, 3'd2, 32'h208, 32'h1234_56AB, 0, 32'h0);
  endtask

  task automatic test_errors;
    run_txn("lw_misaligned", 0, 3'd2, 32'h101, 32'h0, 0, 32'h1111_1111);
    run_txn("lh_misaligned", 0, 3'd5, 32'h103, 32'h0, 0, 32'h1111_1111);
    run_txn("st_illegal", 1, 3'd3, 32'h100, 32'h55, 0, 32'h0);
    run_txn("ld_illegal_mis", 0, 3'd6, 32'h101, 32'h0, 0, 32'h0);
  endtask

  task automatic test_timeout;
    run_txn("timeout_load", 0, 3'd2, 32'h300, 32'h0, 99, 32'hCAFE_F00D);
    run_txn("timeout_store", 1, 3'd2, 32'h304, 32'h9, 99, 32'h0);
    run_txn("ready_3rd_wait", 0, 3'd2, 32'h308, 32'h0, 2, 32'h1357_9BDF);
    run_txn("ready_last_wait", 0, 3'd0, 32'h309, 32'h0, MAX_WAIT, 32'h0000_F000);
  endtask

  task automatic test_reset_mid;
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_store = 1'b0; i_req_funct3 = 3'd2; i_req_addr = 32'h400;
    i_mem_ready = 1'b0;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_mem_valid !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid 2nd bus cycle: got valid %b need 1", o_mem_valid);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if ({o_mem_valid, o_rsp_valid, o_req_ready} !== 3'b000) begin
      n_bad++; $display("FAIL rst_mid in reset: got %b need 000", {o_mem_valid, o_rsp_valid, o_req_ready});
    end
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_mem_ready = 1'($urandom);
      @(negedge i_clk);
      n_cmp++;
      if ({o_mem_valid, o_rsp_valid, o_req_ready} !== 3'b001) begin
        n_bad++; $display("FAIL rst_mid after release: got %b need 001", {o_mem_valid, o_rsp_valid, o_req_ready});
      end
    end
    i_mem_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] addr;
    for (int i = 0; i < 60; i++) begin
      addr = $urandom;
      if (i % 2 == 0) addr[1:0] = 2'b00;
      run_txn("random", 1'($urandom), 3'($urandom), addr, $urandom,
              int'($urandom_range(0, MAX_WAIT + 2)), $urandom);
    end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_stores;
    test_errors;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
